// File: rtl/spi_pt_pkg.sv
// Shared definitions for the SPI daisy-chain pass-through: FSM encoding,
// R/W header encoding and the default chip address width.
package spi_pt_pkg;

  localparam int DEFAULT_ADDR_W = 7;

  // First header bit: 1 selects a write, 0 a read.
  localparam logic WR_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEL  = 2'd2
  } pt_state_e;

endpackage : spi_pt_pkg

// File: rtl/spi_pt_sync.sv
// Single-bit multi-stage synchroniser with asynchronous active-low reset.
module spi_pt_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state always uses non-blocking assignment so every
  // stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : spi_pt_sync

// File: rtl/spi_passthrough_hdr.sv
// Daisy-chain SPI pass-through with in-core header decode (R/W + address).
// Optional macro SPI_PT_BYPASS_EN: raw MISO/IRQ forwarding, selects held at 0.
module spi_passthrough_hdr
  import spi_pt_pkg::*;
#(
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] BCAST_ADDR  = {ADDR_W{1'b1}},
  parameter int                NUM_IRQ     = 1,
  parameter int                SYNC_STAGES = 2
) (
  input  logic               iCLK,
  input  logic               RSTin,
  input  logic               ID_in,
  input  logic               IRQ_in,
  input  logic [ADDR_W-1:0]  setSPIAddr,
  input  logic               SCLKin,
  input  logic               SCSNin,
  input  logic               MOSIin,
  output logic               MISOout,
  input  logic               MISOin,
  output logic               SCLKout,
  output logic               SCSNout,
  output logic               MOSIout,
  output logic               RSTout,
  output logic               sclk_local,
  output logic               scsn_local,
  output logic               mosi_local,
  output logic               rst_local,
  input  logic               miso_local,
  input  logic [NUM_IRQ-1:0] irq_local,
  output logic               IRQout,
  output logic               address_strobe,
  output logic [ADDR_W-1:0]  currentSPIAddr,
  output logic               write_enable,
  output logic               read_select
);

  localparam int CNT_W = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_W);

  // Chain forwarding and local pick-off are purely combinational.
  assign SCLKout    = SCLKin;
  assign SCSNout    = SCSNin;
  assign MOSIout    = MOSIin;
  assign RSTout     = RSTin;
  assign sclk_local = SCLKin;
  assign scsn_local = SCSNin;
  assign mosi_local = MOSIin;

  // Local reset: asserts with RSTin, releases two iCLK edges later.
  logic [1:0] rst_pipe;

  always_ff @(posedge iCLK or negedge RSTin) begin
    if (!RSTin) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_local = ~rst_pipe[1];

  logic id_active;
  logic irq_sync;
  logic sync_sclk;
  logic sync_scsn;
  logic sync_mosi;

  spi_pt_sync #(.STAGES(SYNC_STAGES)) u_sync_id (
    .clk(iCLK), .rst_n(RSTin), .d(ID_in), .q(id_active)
  );

  spi_pt_sync #(.STAGES(SYNC_STAGES)) u_sync_irq (
    .clk(iCLK), .rst_n(RSTin), .d(IRQ_in), .q(irq_sync)
  );

  spi_pt_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(iCLK), .rst_n(RSTin), .d(SCLKin), .q(sync_sclk)
  );

  spi_pt_sync #(.STAGES(SYNC_STAGES)) u_sync_scsn (
    .clk(iCLK), .rst_n(RSTin), .d(SCSNin), .q(sync_scsn)
  );

  spi_pt_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(iCLK), .rst_n(RSTin), .d(MOSIin), .q(sync_mosi)
  );

  logic sclk_d;
  logic sclk_rise;
  logic scsn_active;

  always_ff @(posedge iCLK or negedge RSTin) begin
    if (!RSTin) begin
      sclk_d <= 1'b0;
    end else begin
      sclk_d <= sync_sclk;
    end
  end

  assign sclk_rise   = sync_sclk & ~sclk_d;
  assign scsn_active = ~sync_scsn;

  // Header decode. The shift register keeps only ADDR_W bits; the R/W bit
  // sits at the top of hdr_next exactly on the cycle the last bit arrives.
  pt_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] hdr_sr;
  logic [ADDR_W:0]   hdr_next;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_wr;
  logic              addr_match;
  logic              bcast_match;
  logic              strobe_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              rs_q;

  assign hdr_next    = {hdr_sr, sync_mosi};
  assign hdr_addr    = hdr_next[ADDR_W-1:0];
  assign hdr_wr      = (hdr_next[ADDR_W] == WR_BIT);
  assign addr_match  = (hdr_addr == setSPIAddr);
  assign bcast_match = (hdr_addr == BCAST_ADDR);

  always_ff @(posedge iCLK or negedge RSTin) begin
    if (!RSTin) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      hdr_sr   <= '0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      rs_q     <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          hdr_sr  <= '0;
          we_q    <= 1'b0;
          rs_q    <= 1'b0;
          if (scsn_active) begin
            state <= HDR;
          end
        end

        HDR: begin
          if (!scsn_active) begin
            // Aborted header: no strobe, address register left alone.
            state <= IDLE;
            we_q  <= 1'b0;
            rs_q  <= 1'b0;
          end else if (sclk_rise) begin
            hdr_sr  <= hdr_addr;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state    <= SEL;
              strobe_q <= 1'b1;
              addr_q   <= hdr_addr;
              rs_q     <= id_active & ~hdr_wr & addr_match;
              we_q     <= id_active & hdr_wr & (addr_match | bcast_match);
            end
          end
        end

        SEL: begin
          if (!scsn_active) begin
            state <= IDLE;
            we_q  <= 1'b0;
            rs_q  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          we_q  <= 1'b0;
          rs_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address_strobe = strobe_q;
  assign currentSPIAddr = addr_q;

`ifdef SPI_PT_BYPASS_EN
  // Decode stays alive for debug visibility; nothing local is selected.
  logic unused_bypass;
  assign unused_bypass = ^{irq_sync, miso_local, irq_local, we_q, rs_q};

  assign MISOout      = MISOin;
  assign IRQout       = IRQ_in;
  assign write_enable = 1'b0;
  assign read_select  = 1'b0;
`else
  assign MISOout      = rs_q ? miso_local : MISOin;
  assign IRQout       = irq_sync | (|irq_local);
  assign write_enable = we_q;
  assign read_select  = rs_q;
`endif

endmodule : spi_passthrough_hdr

// File: doc/spi_passthrough_hdr.md
Name: spi_passthrough_hdr

Overview:
- Next-generation daisy-chain SPI pass-through for the miner ASIC chain.
- Forwards SCLK/SCSN/MOSI/RST downstream and picks them off for the local SPI slave. Muxes MISO and ORs IRQs upstream.
- Decodes the frame header (R/W bit + address) itself in the iCLK domain, so no external address strobe is needed.
- Generalises the chip address width, broadcast address and local IRQ count, and splits read and write selection.

Parameters:
- ADDR_W, 7, chip address width in bits.
- BCAST_ADDR, {ADDR_W{1'b1}}, broadcast address; accepted for writes only.
- NUM_IRQ, 1, number of local IRQ sources.
- SYNC_STAGES, 2, synchroniser depth for ID_in, IRQ_in, SCLKin, SCSNin, MOSIin; minimum 2.

Ports:
- iCLK, in, 1, core clock; must be at least 4x SCLK.
- RSTin, in, 1, asynchronous active-low reset.
- ID_in, in, 1, chain ID-enable from the previous chip.
- IRQ_in, in, 1, IRQ from the downstream chip.
- setSPIAddr, in, ADDR_W, this chip's assigned address.
- SCLKin / SCSNin / MOSIin, in, 1 each, SPI from upstream.
- MISOout, out, 1, MISO to upstream.
- MISOin, in, 1, MISO from downstream.
- SCLKout / SCSNout / MOSIout / RSTout, out, 1 each, combinational pass-through of the matching inputs.
- sclk_local / scsn_local / mosi_local, out, 1 each, combinational pick-off of the matching inputs.
- rst_local, out, 1, active-high local reset; asserts asynchronously, deasserts synchronised.
- miso_local, in, 1, local slave MISO.
- irq_local, in, NUM_IRQ, local IRQ sources.
- IRQout, out, 1, IRQ to upstream.
- address_strobe, out, 1, one-cycle pulse when a complete header has been decoded.
- currentSPIAddr, out, ADDR_W, last decoded address.
- write_enable, out, 1, local write permitted for the current frame.
- read_select, out, 1, local slave owns MISO for the current frame.

Behaviour:
- Reset:
  - RSTin low asynchronously clears all flops. Outputs go to: rst_local=1, address_strobe=0, currentSPIAddr=0, write_enable=0, read_select=0.
  - rst_local deasserts after 2 iCLK rising edges with RSTin high.
  - RSTout = RSTin, unsynchronised.
- Synchronisers and edge detect:
  - SCLKin, SCSNin and MOSIin each pass through SYNC_STAGES flops.
  - sclk_rise = sync_sclk & ~sclk_d.
  - scsn_active = ~sync_scsn.
- Frame format:
  - Mode 0.
  - First bit is R/W (1 = write), then ADDR_W address bits, MSB first.
  - Bits are sampled on sclk_rise.
- State machine (3 states):
  - IDLE: scsn_active -> HDR. The bit counter and header shift register are cleared on entry.
  - HDR: each sclk_rise shifts MOSI in and increments the counter.
    - On the (ADDR_W+1)th bit -> SEL. On that cycle: update currentSPIAddr, pulse address_strobe for 1 cycle, evaluate the select outputs.
    - ~scsn_active in HDR -> IDLE (abort). No strobe is issued; currentSPIAddr and the selects are unchanged (still 0 from the last frame end).
  - SEL: hold until ~scsn_active -> IDLE. SCLK edges are ignored for decode.
  - Entering IDLE from any state clears write_enable and read_select in the same cycle.
- Latency: address_strobe is asserted SYNC_STAGES+1 iCLK cycles after the SCLK rising edge of the last header bit.
- Select evaluation (registered, at strobe time; id_active = synchronised ID_in):
  - read_select = id_active & ~wr & (addr == setSPIAddr).
  - write_enable = id_active & wr & ((addr == setSPIAddr) | (addr == BCAST_ADDR)).
  - A read to BCAST_ADDR never sets read_select.
- MISOout = read_select ? miso_local : MISOin.
- IRQout = irq_sync | (|irq_local). IRQ_in is synchronised through SYNC_STAGES.
- Corner cases:
  - SCSN high for exactly one synchronised cycle: state goes to IDLE, then to HDR again next cycle.
  - ID_in falling mid-frame: no effect until the next header.
  - setSPIAddr changing mid-frame: no effect until the next header.

Optional Feature:
- Macro: SPI_PT_BYPASS_EN.
- Defined:
  - MISOout = MISOin; IRQout = IRQ_in, unsynchronised.
  - write_enable and read_select are forced to 0.
  - address_strobe and currentSPIAddr keep working, for debug.
- Undefined: behaviour exactly as specified above.

Decomposition:
- Shared package spi_pt_pkg holds:
  - FSM state encoding: IDLE=2'd0, HDR=2'd1, SEL=2'd2.
  - WR_BIT=1'b1 (write encoding).
  - Default ADDR_W.
- One sub-module, spi_pt_sync: a SYNC_STAGES-deep single-bit synchroniser with async active-low reset. Instantiated for ID, IRQ, SCLK, SCSN and MOSI.

Test Plan (ADDR_W=7, SYNC_STAGES=2, SCLK = iCLK/8):
1. RSTin low mid-frame, then high -> rst_local=1 immediately; rst_local=0 two cycles after release; selects=0; FSM IDLE.
2. ID_in=1, setSPIAddr=7'h12, write frame header 1_0010010 -> one address_strobe pulse; currentSPIAddr=7'h12; write_enable=1 until SCSN rises, then 0.
3. ID_in=1, read frame to 7'h12, miso_local=1, MISOin=0 -> MISOout=1 during frame; read frame to 7'h13 -> MISOout follows MISOin.
4. Write to 7'h7F (broadcast) -> write_enable=1; read to 7'h7F -> read_select=0; ID_in=0 with a matching address -> both selects 0.
5. SCSN rises after 4 header bits -> no address_strobe; currentSPIAddr unchanged; next full frame decodes correctly.
6. irq_local=2'b10 (NUM_IRQ=2), IRQ_in=0 -> IRQout=1; irq_local=0, IRQ_in pulse -> IRQout follows 2 cycles later; with SPI_PT_BYPASS_EN, IRQout=IRQ_in combinationally and MISOout=MISOin.
